// File: rtl/hack_pkg.sv
// Shared Hack memory definitions: widths, upload FSM states and the byte-lane
// convention used by both the download packer and the upload reader.
package hack_pkg;
  localparam int HACK_ADDR_W = 15;
  localparam int HACK_WORD_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAITQ, CAPTURE} upl_state_t;

  // Big-endian: even byte address is the high byte of the word.
  function automatic logic [7:0] lane_sel(input logic [HACK_WORD_W-1:0] word,
                                          input logic a0,
                                          input logic big_endian);
    return (a0 ^ big_endian) ? word[15:8] : word[7:0];
  endfunction
endpackage

// File: rtl/hack_ram_uploader_if.sv
// Upload-side bundle: hps_io byte-read handshake plus the RAM read port.
interface hack_ram_uploader_if #(
  parameter int ADDR_W = hack_pkg::HACK_ADDR_W
);
  logic                            ioctl_upload;
  logic                            ioctl_rd;
  logic [24:0]                     ioctl_addr;
  logic [7:0]                      ioctl_din;
  logic                            ioctl_wait;
  logic                            din_valid;
  logic [ADDR_W-1:0]               mem_addr;
  logic                            mem_rd;
  logic [hack_pkg::HACK_WORD_W-1:0] mem_q;
  logic                            overrun;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, mem_q,
    output ioctl_din, ioctl_wait, din_valid, mem_addr, mem_rd, overrun
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, mem_q,
    input  ioctl_din, ioctl_wait, din_valid, mem_addr, mem_rd, overrun
  );
endinterface

// File: rtl/hack_ram_uploader.sv
// Turns hps_io upload byte reads into 16-bit RAM reads, with a one-word cache
// so the second byte of a pair is served without another RAM access.
module hack_ram_uploader
  import hack_pkg::*;
#(
  parameter int ADDR_W      = HACK_ADDR_W,
  parameter int DEPTH_WORDS = 32768,
  parameter int MEM_LATENCY = 1,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic               clk_sys,
  input  logic               reset,
  hack_ram_uploader_if.slave bus
);

  localparam logic             BE       = (BIG_ENDIAN != 0);
  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 2);

  upl_state_t             state;
  logic                   upload_q;
  logic [ADDR_W-1:0]      req_word;
  logic                   req_a0;
  logic [HACK_WORD_W-1:0] cache_word;
  logic [ADDR_W-1:0]      cache_tag;
  logic                   cache_vld;
  logic [CNT_W-1:0]       wait_cnt;

  logic [ADDR_W-1:0]      rd_word;
  logic                   rd_a0;
  logic                   rd_oor;
  logic                   rd_hit;
  logic                   upload_rise;

  // Request decode: the full 25-bit address is checked, so nothing aliases.
  always_comb begin
    rd_word     = bus.ioctl_addr[ADDR_W:1];
    rd_a0       = bus.ioctl_addr[0];
    rd_oor      = (bus.ioctl_addr[24:ADDR_W+1] != '0) ||
                  (32'(rd_word) >= DEPTH_WORDS);
    upload_rise = bus.ioctl_upload && !upload_q;
    rd_hit      = cache_vld && !upload_rise && (cache_tag == rd_word);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= IDLE;
      upload_q       <= 1'b0;
      cache_vld      <= 1'b0;
      wait_cnt       <= '0;
      bus.ioctl_din  <= '0;
      bus.ioctl_wait <= 1'b0;
      bus.din_valid  <= 1'b0;
      bus.mem_rd     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.overrun    <= 1'b0;
    end else begin
      upload_q      <= bus.ioctl_upload;
      bus.din_valid <= 1'b0;
      bus.mem_rd    <= 1'b0;

      if (upload_rise)
        bus.overrun <= 1'b0;
      else if (bus.ioctl_rd && state != IDLE)
        bus.overrun <= 1'b1;

      // Outside a session the RAM may change, so the cache cannot be trusted;
      // a miss in flight is dropped and its late RAM data is never sampled.
      if (!bus.ioctl_upload) begin
        cache_vld      <= 1'b0;
        state          <= IDLE;
        bus.ioctl_wait <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.ioctl_rd) begin
              if (rd_oor) begin
                bus.ioctl_din <= 8'h00;
                bus.din_valid <= 1'b1;
              end else if (rd_hit) begin
                bus.ioctl_din <= lane_sel(cache_word, rd_a0, BE);
                bus.din_valid <= 1'b1;
              end else begin
                req_word       <= rd_word;
                req_a0         <= rd_a0;
                bus.mem_rd     <= 1'b1;
                bus.mem_addr   <= rd_word;
                bus.ioctl_wait <= 1'b1;
                state          <= ISSUE;
              end
            end
          end
          ISSUE: begin
            wait_cnt <= '0;
            state    <= (MEM_LATENCY == 1) ? CAPTURE : WAITQ;
          end
          WAITQ: begin
            if (wait_cnt == CNT_LAST)
              state <= CAPTURE;
            else
              wait_cnt <= wait_cnt + 1'b1;
          end
          CAPTURE: begin
            cache_word     <= bus.mem_q;
            cache_tag      <= req_word;
            cache_vld      <= 1'b1;
            bus.ioctl_din  <= lane_sel(bus.mem_q, req_a0, BE);
            bus.din_valid  <= 1'b1;
            bus.ioctl_wait <= 1'b0;
            state          <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/hack_ram_uploader.md
Name: hack_ram_uploader

Overview:
- Serves hps_io upload reads: turns byte requests from the HPS (ioctl_rd at a byte address) into 16-bit reads on a synchronous RAM read port.
- Returns the selected byte, high byte first, which is the inverse of the download path that packs byte pairs into ROM words.
- Sits between hps_io (upload side) and a read port of the Hack data RAM or ROM dpram, in the clk_sys domain.
- Holds a one-word cache, so the odd byte of a pair costs no second RAM access.

Parameters:
ADDR_W, 15, word address width of the memory read port
DEPTH_WORDS, 32768, number of valid words; word addresses >= DEPTH_WORDS read as 0x00
MEM_LATENCY, 1, clk_sys cycles from mem_rd to valid mem_q (legal range 1..3)
BIG_ENDIAN, 1, 1: even byte address = word[15:8]; 0: even byte address = word[7:0]

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
ioctl_upload  in  1  high for the whole upload session
ioctl_rd  in  1  one-cycle byte read request
ioctl_addr  in  25  byte address of the request, sampled with ioctl_rd
ioctl_din  out  8  returned byte; held until the next completion
ioctl_wait  out  1  high while a miss is outstanding
din_valid  out  1  one-cycle pulse in the cycle ioctl_din becomes valid
mem_addr  out  ADDR_W  word address to the RAM read port
mem_rd  out  1  one-cycle read strobe
mem_q  in  16  RAM read data, valid MEM_LATENCY cycles after mem_rd
overrun  out  1  sticky flag: ioctl_rd arrived while busy; cleared by reset or a new session

Behaviour:
- Reset (synchronous, active-high, dominates everything): state=IDLE, ioctl_din=0, ioctl_wait=0, din_valid=0, mem_rd=0, mem_addr=0, overrun=0, cache invalid.
- Address decode:
  - word = ioctl_addr[ADDR_W:1].
  - The byte lane is selected by ioctl_addr[0] and BIG_ENDIAN.
  - ioctl_addr bits above ADDR_W that are nonzero, or word >= DEPTH_WORDS, mark the request out of range.
- State machine: IDLE -> ISSUE -> WAITQ -> CAPTURE -> IDLE.
- IDLE: ioctl_rd is accepted only when ioctl_upload=1; otherwise it is ignored.
  - Cache hit (cache valid and cached word == word): next cycle ioctl_din = selected lane of the cached word, din_valid=1, ioctl_wait never asserted. Latency 1.
  - Out of range: next cycle ioctl_din=0x00, din_valid=1, no RAM access, cache unchanged. Latency 1.
  - Miss: latch word and lane, go to ISSUE.
- ISSUE (1 cycle): mem_rd=1, mem_addr=word, ioctl_wait=1. Go to WAITQ.
- WAITQ: ioctl_wait=1; a counter runs MEM_LATENCY-1 cycles, which is 0 when MEM_LATENCY=1. Then go to CAPTURE.
- CAPTURE: sample mem_q into the cache word, cache valid=1, cache tag=word, ioctl_wait=1.
- The next cycle returns to IDLE with ioctl_din = selected lane, din_valid=1, ioctl_wait=0.
- Miss latency, ioctl_rd to din_valid: MEM_LATENCY+2 cycles. ioctl_wait is high from the cycle after ioctl_rd up to, but not including, the din_valid cycle.
- mem_rd is a single-cycle pulse; mem_addr holds its value until the next ISSUE.
- ioctl_rd outside IDLE: ignored, overrun<=1; the current request completes unaffected.
- ioctl_upload rising edge: cache invalidated, overrun cleared (RAM may have changed between sessions).
- ioctl_upload falling mid-miss: abort to IDLE next cycle.
  - ioctl_wait=0, no din_valid, cache invalidated.
  - ioctl_din keeps its previous value.
  - A RAM response already in flight is discarded.
- ioctl_rd in the same cycle as the rising edge of ioctl_upload is accepted and treated as a miss.
- Byte address wrap: none. The full 25-bit address is compared, so address 2*DEPTH_WORDS is out of range and does not alias to word 0.

Decomposition:
- Shared package hack_pkg holds:
  - HACK_ADDR_W=15 and HACK_WORD_W=16.
  - The state enum typedef upl_state_t {IDLE, ISSUE, WAITQ, CAPTURE}.
  - A byte-lane select function lane_sel(word, a0, big_endian).
- The download byte-packer uses the same lane convention from this package.
- No sub-module: the latency counter and the one-word cache are inline. The block is about 150-200 lines.

Test Plan:
- Preload RAM[0]=0xA55A, upload=1, rd addr 0 then addr 1 -> din 0xA5 after 3 cycles with ioctl_wait high for 2 cycles; then din 0x5A after 1 cycle with no wait and no second mem_rd.
- MEM_LATENCY=3, RAM[0x1234]=0xBEEF, rd addr 0x2469 -> mem_addr=0x1234, din 0xEF exactly 5 cycles after rd. Repeat with BIG_ENDIAN=0 -> 0xBE.
- DEPTH_WORDS=16384, rd addr 0x8000 -> din 0x00 one cycle later, no mem_rd. rd addr 0x1_0000 -> also 0x00, with no alias to word 0.
- rd during ISSUE of a miss -> overrun=1, first request returns the correct byte, the second yields no din_valid. Toggle upload off/on -> overrun=0.
- Drop upload in WAITQ -> no din_valid, ioctl_wait=0 next cycle. Re-upload and rd the same word -> a fresh mem_rd is issued (cache invalidated).
- Assert reset in CAPTURE -> all outputs 0 next cycle. rd without upload -> ignored, no mem_rd.
